// File: rtl/atmega_pio_pcint_if.sv
// Purpose: register bus between a host and the pin-change PIO block.
// Latency: combinational read data; writes take effect on the next clk edge.
// Backpressure: none; every rd/wr strobe is accepted in the cycle it is presented.
// Signals: addr (register address), wr/rd (strobes), bus_in (write data), bus_out (read data).
interface atmega_pio_pcint_if #(
  parameter int BUS_ADDR_DATA_LEN = 8,
  parameter int PORT_WIDTH        = 8
);
  logic [BUS_ADDR_DATA_LEN-1:0] addr;
  logic                         wr;
  logic                         rd;
  logic [PORT_WIDTH-1:0]        bus_in;
  logic [PORT_WIDTH-1:0]        bus_out;

  modport master (output addr, output wr, output rd, output bus_in, input bus_out);
  modport slave  (input addr, input wr, input rd, input bus_in, output bus_out);
endinterface

// File: rtl/atmega_pio_pcint.sv
// Purpose: AVR-style GPIO port with synchronised inputs and pin-change interrupt flags.
// Latency: pad -> PIN in SYNC_STAGES cycles, pad edge -> IFR/irq in SYNC_STAGES+1; reads combinational.
// Backpressure: none; bus strobes always accepted, pads sampled every cycle.
// Ports: clk, rst (sync, active-low), bus (register access), io_in (async pads),
//        io_out (pad drive, z when undriven), pio_out_io_connect (output enable), irq.
module atmega_pio_pcint #(
  parameter int                             BUS_ADDR_DATA_LEN    = 8,
  parameter int                             PORT_WIDTH           = 8,
  parameter int                             SYNC_STAGES          = 2,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   PORT_ADDR            = 'h00,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   DDR_ADDR             = 'h01,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   PIN_ADDR             = 'h02,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   RISE_ADDR            = 'h03,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   FALL_ADDR            = 'h04,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   IFR_ADDR             = 'h05,
  parameter logic [PORT_WIDTH-1:0]          PINMASK              = {PORT_WIDTH{1'b1}},
  parameter logic [PORT_WIDTH-1:0]          INVERSE_MASK         = '0,
  parameter logic [PORT_WIDTH-1:0]          INITIAL_OUTPUT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  atmega_pio_pcint_if.slave     bus,
  input  logic [PORT_WIDTH-1:0] io_in,
  output wire  [PORT_WIDTH-1:0] io_out,
  output logic [PORT_WIDTH-1:0] pio_out_io_connect,
  output logic                  irq
);

  localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync_q;
  logic [PORT_WIDTH-1:0] pin;
  logic [PORT_WIDTH-1:0] pin_d;
  logic [PORT_WIDTH-1:0] port_q;
  logic [PORT_WIDTH-1:0] ddr_q;
  logic [PORT_WIDTH-1:0] rise_q;
  logic [PORT_WIDTH-1:0] fall_q;
  logic [PORT_WIDTH-1:0] ifr_q;
  logic [2:0]            warm_q;

  logic sel_port, sel_ddr, sel_pin, sel_rise, sel_fall, sel_ifr;
  logic edge_ok;
  logic [PORT_WIDTH-1:0] rise_det, fall_det, flag_set, flag_clr;
  logic [PORT_WIDTH-1:0] rd_mux;

  assign pin = sync_q[SYNC_STAGES-1];

  // Full-width compare so aliases of the register map decode as unmapped.
  assign sel_port = (bus.addr == PORT_ADDR);
  assign sel_ddr  = (bus.addr == DDR_ADDR);
  assign sel_pin  = (bus.addr == PIN_ADDR);
  assign sel_rise = (bus.addr == RISE_ADDR);
  assign sel_fall = (bus.addr == FALL_ADDR);
  assign sel_ifr  = (bus.addr == IFR_ADDR);

  // Edges are judged on the raw pad level; INVERSE_MASK only affects what software sees.
  // The warm-up window hides the 0->pad transition the chain makes after reset.
  assign edge_ok  = (warm_q == 3'd0);
  assign rise_det = pin & ~pin_d;
  assign fall_det = ~pin & pin_d;
  assign flag_set = ((rise_det & rise_q) | (fall_det & fall_q)) & PINMASK & {PORT_WIDTH{edge_ok}};
  assign flag_clr = (bus.wr && sel_ifr) ? bus.bus_in : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      pin_d  <= '0;
      port_q <= INITIAL_OUTPUT_VALUE & PINMASK;
      ddr_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      ifr_q  <= '0;
      warm_q <= WARM_LOAD;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_in};
      pin_d  <= pin;
      if (warm_q != 3'd0) warm_q <= warm_q - 3'd1;

      if (bus.wr && sel_port)     port_q <= bus.bus_in & PINMASK;
      else if (bus.wr && sel_pin) port_q <= (port_q ^ bus.bus_in) & PINMASK;
      if (bus.wr && sel_ddr)  ddr_q  <= bus.bus_in & PINMASK;
      if (bus.wr && sel_rise) rise_q <= bus.bus_in & PINMASK;
      if (bus.wr && sel_fall) fall_q <= bus.bus_in & PINMASK;

      // Set is OR-ed in after the clear so a simultaneous new edge keeps its flag.
      ifr_q <= ((ifr_q & ~flag_clr) | flag_set) & PINMASK;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_port)      rd_mux = port_q;
    else if (sel_ddr)  rd_mux = ddr_q;
    else if (sel_pin)  rd_mux = (pin ^ INVERSE_MASK) & PINMASK;
    else if (sel_rise) rd_mux = rise_q;
    else if (sel_fall) rd_mux = fall_q;
    else if (sel_ifr)  rd_mux = ifr_q;
  end

  // Outputs are gated by rst so they sit at reset values for the whole reset window.
  assign bus.bus_out         = (bus.rd && rst) ? rd_mux : '0;
  assign irq                 = rst && (|ifr_q);
  assign pio_out_io_connect  = rst ? ddr_q : '0;

  for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pad
    assign io_out[i] = (rst && ddr_q[i]) ? (port_q[i] ^ INVERSE_MASK[i]) : 1'bz;
  end

endmodule

// File: tb/tb_atmega_pio_pcint.sv
module tb_atmega_pio_pcint;

  localparam logic [7:0] A_PORT = 8'h00, A_DDR = 8'h01, A_PIN = 8'h02;
  localparam logic [7:0] A_RISE = 8'h03, A_FALL = 8'h04, A_IFR = 8'h05;

  // Expectation kinds: bus reads per DUT, then probes of irq / oe / driven pad bits.
  localparam int K_RD0 = 0, K_RD1 = 1, K_RD2 = 2;
  localparam int K_IRQ0 = 3, K_IRQ1 = 4, K_IRQ2 = 5;
  localparam int K_OE0 = 6, K_OE1 = 7, K_OE2 = 8;
  localparam int K_IO0 = 9, K_IO1 = 10, K_IO2 = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] io_in0, io_in1, io_in2;
  wire  [7:0] io_out0, io_out1, io_out2;
  logic [7:0] oe0, oe1, oe2;
  logic irq0, irq1, irq2;
  logic probe;
  int   probe_kind;

  int checks = 0;
  int failures = 0;

  typedef struct { int kind; logic [7:0] exp; } exp_t;
  exp_t  sb_q[$];
  string nm_q[$];

  always #5 clk = ~clk;

  atmega_pio_pcint_if #(.BUS_ADDR_DATA_LEN(8), .PORT_WIDTH(8)) b0 ();
  atmega_pio_pcint_if #(.BUS_ADDR_DATA_LEN(8), .PORT_WIDTH(8)) b1 ();
  atmega_pio_pcint_if #(.BUS_ADDR_DATA_LEN(8), .PORT_WIDTH(8)) b2 ();

  atmega_pio_pcint #(.PORT_WIDTH(8), .SYNC_STAGES(2)) d0 (
    .clk(clk), .rst(rst), .bus(b0), .io_in(io_in0), .io_out(io_out0),
    .pio_out_io_connect(oe0), .irq(irq0));

  atmega_pio_pcint #(.PORT_WIDTH(8), .SYNC_STAGES(2), .INVERSE_MASK(8'h80)) d1 (
    .clk(clk), .rst(rst), .bus(b1), .io_in(io_in1), .io_out(io_out1),
    .pio_out_io_connect(oe1), .irq(irq1));

  atmega_pio_pcint #(.PORT_WIDTH(8), .SYNC_STAGES(2), .PINMASK(8'h7F),
                     .INITIAL_OUTPUT_VALUE(8'hC3)) d2 (
    .clk(clk), .rst(rst), .bus(b2), .io_in(io_in2), .io_out(io_out2),
    .pio_out_io_connect(oe2), .irq(irq2));

  // ---------------- monitor / scoreboard ----------------
  function automatic logic [7:0] actual(input int kind);
    case (kind)
      K_RD0:  return b0.bus_out;
      K_RD1:  return b1.bus_out;
      K_RD2:  return b2.bus_out;
      K_IRQ0: return {7'd0, irq0};
      K_IRQ1: return {7'd0, irq1};
      K_IRQ2: return {7'd0, irq2};
      K_OE0:  return oe0;
      K_OE1:  return oe1;
      K_OE2:  return oe2;
      K_IO0:  return io_out0 & oe0;
      K_IO1:  return io_out1 & oe1;
      K_IO2:  return io_out2 & oe2;
      default: return 8'hxx;
    endcase
  endfunction

  task automatic check_one(input int want);
    exp_t e;
    string n;
    logic [7:0] act;
    bit kind_ok;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_underflow: DUT output presented (source %0d) with nothing expected", want);
      return;
    end
    e = sb_q.pop_front();
    n = nm_q.pop_front();
    act = actual(e.kind);
    kind_ok = (want >= 0) ? (e.kind == want) : (e.kind >= K_IRQ0);
    if (!kind_ok || act !== e.exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h (kind %0d)", n, act, e.exp, e.kind);
    end
  endtask

  always @(negedge clk) begin
    if (b0.rd) check_one(K_RD0);
    if (b1.rd) check_one(K_RD1);
    if (b2.rd) check_one(K_RD2);
    if (probe) check_one(-1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input int kind, input logic [7:0] e, input string n);
    exp_t x;
    x.kind = kind;
    x.exp  = e;
    sb_q.push_back(x);
    nm_q.push_back(n);
  endtask

  // Within one cycle, issue reads in DUT order 0,1,2 and at most one probe last.
  task automatic rd(input int s, input logic [7:0] a, input logic [7:0] e, input string n);
    case (s)
      0: begin b0.rd = 1'b1; b0.addr = a; end
      1: begin b1.rd = 1'b1; b1.addr = a; end
      default: begin b2.rd = 1'b1; b2.addr = a; end
    endcase
    push(s, e, n);
  endtask

  task automatic wr(input int s, input logic [7:0] a, input logic [7:0] d);
    case (s)
      0: begin b0.wr = 1'b1; b0.addr = a; b0.bus_in = d; end
      1: begin b1.wr = 1'b1; b1.addr = a; b1.bus_in = d; end
      default: begin b2.wr = 1'b1; b2.addr = a; b2.bus_in = d; end
    endcase
  endtask

  task automatic prb(input int kind, input logic [7:0] e, input string n);
    probe = 1'b1;
    probe_kind = kind;
    push(kind, e, n);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    b0.rd = 1'b0; b0.wr = 1'b0;
    b1.rd = 1'b0; b1.wr = 1'b0;
    b2.rd = 1'b0; b2.wr = 1'b0;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.rd = 0; b0.wr = 0; b0.addr = 0; b0.bus_in = 0;
    b1.rd = 0; b1.wr = 0; b1.addr = 0; b1.bus_in = 0;
    b2.rd = 0; b2.wr = 0; b2.addr = 0; b2.bus_in = 0;
    probe = 0; probe_kind = 0;
    io_in0 = 8'hFF; io_in1 = 8'h80; io_in2 = 8'h00;
    rst = 1'b0;
    idle(3);

    // Reset: outputs held even with rd asserted and a nonzero stored PORT (d2).
    rd(0, A_PORT, 8'h00, "rst_bus0"); rd(2, A_PORT, 8'h00, "rst_bus2"); prb(K_IRQ0, 8'h00, "rst_irq0"); cyc();
    prb(K_OE0, 8'h00, "rst_oe0"); cyc();

    // Warm-up: pad high through reset, RISE enabled right at release -> no flag.
    rst = 1'b1;
    wr(0, A_RISE, 8'hFF); cyc();
    idle(6);
    rd(0, A_IFR, 8'h00, "warm_ifr"); prb(K_IRQ0, 8'h00, "warm_irq"); cyc();
    rd(0, A_RISE, 8'hFF, "rise_rb"); cyc();

    // d1: inverted pin 7, falling edge on the pad sets the flag.
    wr(1, A_FALL, 8'h80); cyc();
    rd(1, A_PIN, 8'h00, "inv_pin_hi"); cyc();
    io_in1 = 8'h00; cyc(); cyc();
    rd(1, A_PIN, 8'h80, "inv_pin_lo"); cyc();
    rd(1, A_IFR, 8'h80, "inv_fall_ifr"); prb(K_IRQ1, 8'h01, "inv_fall_irq"); cyc();
    wr(1, A_DDR, 8'h80); cyc();
    prb(K_IO1, 8'h80, "inv_io"); cyc();
    prb(K_OE1, 8'h80, "inv_oe"); cyc();

    // d2: pin 7 unimplemented.
    rd(2, A_PORT, 8'h43, "init_port_masked"); cyc();
    wr(2, A_DDR, 8'hFF); cyc();
    rd(2, A_DDR, 8'h7F, "mask_ddr"); prb(K_OE2, 8'h7F, "mask_oe"); cyc();
    wr(2, A_RISE, 8'hFF); cyc();
    wr(2, A_FALL, 8'hFF); cyc();
    rd(2, A_FALL, 8'h7F, "mask_fall"); cyc();
    io_in2 = 8'h80; idle(4);
    io_in2 = 8'h00; idle(4);
    rd(2, A_IFR, 8'h00, "mask_ifr7"); prb(K_IRQ2, 8'h00, "mask_irq"); cyc();
    rd(2, A_PIN, 8'h00, "mask_pin"); prb(K_IO2, 8'h43, "mask_io"); cyc();
    io_in2 = 8'h01; idle(4);
    rd(2, A_IFR, 8'h01, "mask_ifr0"); cyc();

    // d0: rising edge latency on pin 0.
    io_in0 = 8'h00; idle(4);
    wr(0, A_RISE, 8'h01); cyc();
    rd(0, A_IFR, 8'h00, "fall_no_en"); cyc();
    io_in0 = 8'h01; cyc();
    rd(0, A_PIN, 8'h00, "pin_lat1"); cyc();
    rd(0, A_PIN, 8'h01, "pin_lat2"); prb(K_IRQ0, 8'h00, "irq_lat2"); cyc();
    rd(0, A_IFR, 8'h01, "ifr_lat3"); prb(K_IRQ0, 8'h01, "irq_lat3"); cyc();

    // Sticky flag, W1C, then set-wins collision.
    io_in0 = 8'h00; idle(4);
    rd(0, A_IFR, 8'h01, "ifr_sticky"); cyc();
    wr(0, A_IFR, 8'h01); cyc();
    rd(0, A_IFR, 8'h00, "w1c"); prb(K_IRQ0, 8'h00, "w1c_irq"); cyc();
    io_in0 = 8'h01; cyc(); cyc();
    wr(0, A_IFR, 8'h01); cyc();
    rd(0, A_IFR, 8'h01, "set_wins"); prb(K_IRQ0, 8'h01, "set_wins_irq"); cyc();
    wr(0, A_IFR, 8'hFF); cyc();
    rd(0, A_IFR, 8'h00, "w1c_all"); cyc();

    // PORT/DDR/PIN-toggle and pad drive.
    wr(0, A_PORT, 8'hA5); cyc();
    wr(0, A_DDR, 8'h0F); cyc();
    wr(0, A_PIN, 8'hFF); cyc();
    rd(0, A_PORT, 8'h5A, "pin_toggle"); prb(K_IO0, 8'h0A, "pad_drive"); cyc();
    rd(0, A_DDR, 8'h0F, "ddr_rb"); prb(K_OE0, 8'h0F, "pad_oe"); cyc();

    // Unmapped address, then read/write collision.
    wr(0, 8'h10, 8'hFF); cyc();
    rd(0, 8'h10, 8'h00, "unmapped_rd"); cyc();
    rd(0, A_PORT, 8'h5A, "unmapped_no_wr"); cyc();
    rd(0, 8'h06, 8'h00, "unmapped_rd6"); cyc();
    rd(0, A_PORT, 8'h5A, "rdwr_old"); wr(0, A_PORT, 8'h33); cyc();
    rd(0, A_PORT, 8'h33, "rdwr_new"); cyc();

    // Reset with an interrupt pending.
    io_in0 = 8'h00; idle(3);
    io_in0 = 8'h01; idle(4);
    prb(K_IRQ0, 8'h01, "pre_rst_irq"); cyc();
    rst = 1'b0;
    prb(K_IRQ0, 8'h00, "rst_irq_drop"); cyc();
    rst = 1'b1;
    rd(0, A_IFR, 8'h00, "rst_ifr_clr"); prb(K_OE0, 8'h00, "rst_oe_clr"); cyc();
    rd(0, A_PORT, 8'h00, "rst_port_clr"); cyc();
    rd(0, A_RISE, 8'h00, "rst_rise_clr"); cyc();
    idle(2);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
